// File: rtl/sram_arbiter_2p.sv
// Two-requester arbiter/sequencer for a single-port SRAM macro (CEN active-low,
// WEN 1=read). Round-robin or fixed priority, with bounded burst locking.
module sram_arbiter_2p #(
  parameter int AW        = 11,
  parameter int DW        = 32,
  parameter int FIXED_PRI = 0,
  parameter int LOCK_MAX  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_wen,
  input  logic [1:0]    req_lock,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic [1:0]    r_state;
  logic          r_rr_ptr;
  logic [7:0]    r_lock_cnt;
  logic [1:0]    r_relock_blk;
  logic [1:0]    r_rsp_valid;

  logic          w_gnt_any;
  logic          w_gnt_idx;
  logic          w_gnt_rd;
  logic          w_gnt_lock;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_wdata;
  logic          w_lock_idx;
  logic          w_lock_hold;
  logic          w_cnt_hit;

  // NOTE: reset gates the grant combinationally so the macro stays deselected
  // for the whole time reset is high, not just after the first edge.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_LOCK0: w_gnt_any = req_valid[0];
        ST_LOCK1: begin
          w_gnt_any = req_valid[1];
          w_gnt_idx = 1'b1;
        end
        default: begin
          w_gnt_any = |req_valid;
          if (&req_valid) w_gnt_idx = (FIXED_PRI != 0) ? 1'b0 : r_rr_ptr;
          else            w_gnt_idx = req_valid[1];
        end
      endcase
    end
  end

  assign w_gnt_rd    = w_gnt_idx ? req_wen[1]  : req_wen[0];
  assign w_gnt_lock  = w_gnt_idx ? req_lock[1] : req_lock[0];
  assign w_gnt_addr  = w_gnt_idx ? req_addr1   : req_addr0;
  assign w_gnt_wdata = w_gnt_idx ? req_wdata1  : req_wdata0;

  assign req_ready = {w_gnt_any & w_gnt_idx, w_gnt_any & ~w_gnt_idx};
  assign sram_cen  = ~w_gnt_any;
  assign sram_wen  = w_gnt_any ? w_gnt_rd    : 1'b1;
  assign sram_a    = w_gnt_any ? w_gnt_addr  : '0;
  assign sram_d    = w_gnt_any ? w_gnt_wdata : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = sram_q;

  // Lock owner view: exit when the owner drops lock or its burst fills up.
  assign w_lock_idx  = (r_state == ST_LOCK1);
  assign w_lock_hold = w_lock_idx ? req_lock[1] : req_lock[0];
  assign w_cnt_hit   = w_gnt_any && ((r_lock_cnt + 8'd1) == LOCK_LIM);

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ARB;
      r_rr_ptr     <= 1'b0;
      r_lock_cnt   <= 8'd0;
      r_relock_blk <= 2'b00;
      r_rsp_valid  <= 2'b00;
    end else begin
      r_rsp_valid <= (w_gnt_any && w_gnt_rd) ? req_ready : 2'b00;
      if (w_gnt_any) begin
        r_rr_ptr                <= ~w_gnt_idx;
        r_relock_blk[~w_gnt_idx] <= 1'b0;
      end
      case (r_state)
        ST_ARB: begin
          if (w_gnt_any && w_gnt_lock &&
              (!r_relock_blk[w_gnt_idx] || !req_valid[~w_gnt_idx])) begin
            if (LOCK_LIM == 8'd1) begin
              r_relock_blk[w_gnt_idx] <= 1'b1;
            end else begin
              r_state                 <= w_gnt_idx ? ST_LOCK1 : ST_LOCK0;
              r_lock_cnt              <= 8'd1;
              r_relock_blk[w_gnt_idx] <= 1'b0;
            end
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (w_cnt_hit || !w_lock_hold) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= ~w_lock_idx;
            r_lock_cnt <= 8'd0;
            if (w_cnt_hit) r_relock_blk[w_lock_idx] <= 1'b1;
          end else if (w_gnt_any) begin
            r_lock_cnt <= r_lock_cnt + 8'd1;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Randomised and directed bench for sram_arbiter_2p: a round-robin instance
// (LOCK_MAX=4) and a fixed-priority instance (LOCK_MAX=1) against a rule model.
module tb_sram_arbiter_2p;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    vld [2];
  logic [1:0]    wen [2];
  logic [1:0]    lck [2];
  logic [AW-1:0] addr[2][2];
  logic [DW-1:0] wdat[2][2];
  logic [1:0]    rdy [2];
  logic [1:0]    rspv[2];
  logic [DW-1:0] rspd[2];
  logic          cen [2];
  logic          swen[2];
  logic [AW-1:0] sa  [2];
  logic [DW-1:0] sd  [2];
  logic [DW-1:0] sq  [2];

  sram_arbiter_2p #(.AW(AW), .DW(DW), .FIXED_PRI(0), .LOCK_MAX(4)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_wen(wen[0]), .req_lock(lck[0]), .req_addr0(addr[0][0]), .req_addr1(addr[0][1]),
    .req_wdata0(wdat[0][0]), .req_wdata1(wdat[0][1]), .rsp_valid(rspv[0]), .rsp_data(rspd[0]),
    .sram_cen(cen[0]), .sram_wen(swen[0]), .sram_a(sa[0]), .sram_d(sd[0]), .sram_q(sq[0]));

  sram_arbiter_2p #(.AW(AW), .DW(DW), .FIXED_PRI(1), .LOCK_MAX(1)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_wen(wen[1]), .req_lock(lck[1]), .req_addr0(addr[1][0]), .req_addr1(addr[1][1]),
    .req_wdata0(wdat[1][0]), .req_wdata1(wdat[1][1]), .rsp_valid(rspv[1]), .rsp_data(rspd[1]),
    .sram_cen(cen[1]), .sram_wen(swen[1]), .sram_a(sa[1]), .sram_d(sd[1]), .sram_q(sq[1]));

  // Behavioural SRAM macros: Q updates on the read edge.
  logic [DW-1:0] sram_mem[2][2**AW];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!cen[d]) begin
        if (!swen[d]) sram_mem[d][sa[d]] <= sd[d];
        else          sq[d] <= sram_mem[d][sa[d]];
      end
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner of the current lock burst (-1 = open arbitration).
  int            lmax[2]      = '{4, 1};
  bit            fixed_pri[2] = '{1'b0, 1'b1};
  int            m_owner[2];
  int            m_pref[2];
  int            m_cnt[2];
  bit            m_blk[2][2];
  logic [1:0]    m_rsp[2];
  logic [DW-1:0] m_rsp_data[2];
  logic [DW-1:0] exp_mem[2][2**AW];

  logic [1:0]    last_rdy[2];
  logic [1:0]    last_rspv[2];
  logic          last_cen[2];
  logic [DW-1:0] last_rspd[2];
  int            last_g[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_pref[d]  = 0;
      m_cnt[d]   = 0;
      m_blk[d][0] = 1'b0;
      m_blk[d][1] = 1'b0;
      m_rsp[d]   = 2'b00;
      last_g[d]  = -1;
    end
  endfunction

  function automatic int exp_grant(int d);
    if (m_owner[d] >= 0) return vld[d][m_owner[d]] ? m_owner[d] : -1;
    if (vld[d] == 2'b11) return fixed_pri[d] ? 0 : m_pref[d];
    if (vld[d][0]) return 0;
    if (vld[d][1]) return 1;
    return -1;
  endfunction

  function automatic void model_edge(int d, int g);
    m_rsp[d] = 2'b00;
    if (g >= 0) begin
      if (wen[d][g]) begin
        m_rsp[d]      = (g == 0) ? 2'b01 : 2'b10;
        m_rsp_data[d] = exp_mem[d][addr[d][g]];
      end else begin
        exp_mem[d][addr[d][g]] = wdat[d][g];
      end
      m_pref[d]       = 1 - g;
      m_blk[d][1 - g] = 1'b0;
    end
    if (m_owner[d] < 0) begin
      if (g >= 0 && lck[d][g] && (!m_blk[d][g] || !vld[d][1 - g])) begin
        if (lmax[d] == 1) m_blk[d][g] = 1'b1;
        else begin
          m_owner[d]  = g;
          m_cnt[d]    = 1;
          m_blk[d][g] = 1'b0;
        end
      end
    end else begin
      int o;
      bit hit;
      o   = m_owner[d];
      hit = 1'b0;
      if (g == o) begin
        m_cnt[d]++;
        hit = (m_cnt[d] == lmax[d]);
      end
      if (!lck[d][o] || hit) begin
        m_owner[d] = -1;
        m_pref[d]  = 1 - o;
        m_cnt[d]   = 0;
        if (hit) m_blk[d][o] = 1'b1;
      end
    end
  endfunction

  // One clock: check both DUTs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    int g[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [31:0] e_rdy, e_wen, e_a, e_d;
      g[d] = exp_grant(d);
      if (g[d] < 0) begin
        e_rdy = 0; e_wen = 1; e_a = 0; e_d = 0;
      end else begin
        e_rdy = (g[d] == 0) ? 32'd1 : 32'd2;
        e_wen = 32'(wen[d][g[d]]);
        e_a   = 32'(addr[d][g[d]]);
        e_d   = wdat[d][g[d]];
      end
      check($sformatf("d%0d_ready", d), 32'(rdy[d]), e_rdy);
      check($sformatf("d%0d_cen", d), 32'(cen[d]), (g[d] < 0) ? 32'd1 : 32'd0);
      check($sformatf("d%0d_wen", d), 32'(swen[d]), e_wen);
      check($sformatf("d%0d_addr", d), 32'(sa[d]), e_a);
      check($sformatf("d%0d_wdata", d), sd[d], e_d);
      check($sformatf("d%0d_rspv", d), 32'(rspv[d]), 32'(m_rsp[d]));
      if (m_rsp[d] != 2'b00) check($sformatf("d%0d_rspd", d), rspd[d], m_rsp_data[d]);
      last_rdy[d]  = rdy[d];
      last_rspv[d] = rspv[d];
      last_cen[d]  = cen[d];
      last_rspd[d] = rspd[d];
      last_g[d]    = g[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, g[d]);
    #1;
  endtask

  task automatic drive(input int d, input int i, input bit v, input bit w, input bit l,
                       input int a, input logic [DW-1:0] wd);
    vld[d][i]  = v;
    wen[d][i]  = w;
    lck[d][i]  = l;
    addr[d][i] = AW'(a);
    wdat[d][i] = wd;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++) drive(d, i, 1'b0, 1'b1, 1'b0, 0, '0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_rst_ready", d), 32'(rdy[d]), 0);
        check($sformatf("d%0d_rst_cen", d), 32'(cen[d]), 1);
        check($sformatf("d%0d_rst_rspv", d), 32'(rspv[d]), 0);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Random requesters obey the hold rule: a stalled request keeps its fields.
  task automatic rand_drive(input bit sticky_lock);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(vld[d][i] && last_g[d] != i)) begin
          int a;
          a = ($urandom_range(0, 15) == 0) ? 2047 : int'($urandom_range(0, 7));
          drive(d, i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                sticky_lock ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0),
                a, $urandom);
        end
      end
    end
  endtask

  logic [1:0] t_rdy_seq[10];
  logic [1:0] t_rsp_seq[5];

  initial begin
    idle_all();
    vld[0] = 2'b11;
    vld[1] = 2'b11;
    apply_reset();
    idle_all();

    // Prefill every address the stimulus may read.
    for (int k = 0; k < 9; k++) begin
      for (int d = 0; d < 2; d++) drive(d, 0, 1'b1, 1'b0, 1'b0, (k == 8) ? 2047 : k, $urandom);
      cycle();
    end
    idle_all();

    // Write then read-back by the other requester.
    drive(0, 0, 1'b1, 1'b0, 1'b0, 5, 32'hDEADBEEF);
    cycle();
    idle_all();
    drive(0, 1, 1'b1, 1'b1, 1'b0, 5, '0);
    cycle();
    check("t1_ready", 32'(last_rdy[0]), 32'h2);
    idle_all();
    cycle();
    check("t1_rspv", 32'(last_rspv[0]), 32'h2);
    check("t1_rspd", last_rspd[0], 32'hDEADBEEF);

    // Round-robin alternation of continuous reads.
    apply_reset();
    idle_all();
    drive(0, 0, 1'b1, 1'b1, 1'b0, 3, '0);
    drive(0, 1, 1'b1, 1'b1, 1'b0, 4, '0);
    t_rdy_seq[0:4] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    t_rsp_seq      = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("t2_ready_%0d", k), 32'(last_rdy[0]), 32'(t_rdy_seq[k]));
      check($sformatf("t2_rspv_%0d", k), 32'(last_rspv[0]), 32'(t_rsp_seq[k]));
    end
    idle_all();

    // Fixed priority: requester 0 always wins.
    drive(1, 0, 1'b1, 1'b1, 1'b0, 1, '0);
    drive(1, 1, 1'b1, 1'b1, 1'b0, 2, '0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("t3_ready_%0d", k), 32'(last_rdy[1]), 32'h1);
      check($sformatf("t3_cen_%0d", k), 32'(last_cen[1]), 32'h0);
    end
    idle_all();

    // Bounded lock burst, forced exit, one grant to the other, re-lock.
    apply_reset();
    idle_all();
    drive(0, 0, 1'b1, 1'b1, 1'b1, 1, '0);
    drive(0, 1, 1'b1, 1'b1, 1'b0, 2, '0);
    t_rdy_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int k = 0; k < 10; k++) begin
      cycle();
      check($sformatf("t4_ready_%0d", k), 32'(last_rdy[0]), 32'(t_rdy_seq[k]));
    end
    idle_all();

    // Lock owner idle: the other requester stalls.
    apply_reset();
    idle_all();
    drive(0, 0, 1'b1, 1'b1, 1'b1, 1, '0);
    drive(0, 1, 1'b1, 1'b1, 1'b0, 2, '0);
    cycle();
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1, '0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      check($sformatf("t5_cen_%0d", k), 32'(last_cen[0]), 32'h1);
      check($sformatf("t5_ready_%0d", k), 32'(last_rdy[0]), 32'h0);
    end
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1, '0);
    cycle();
    cycle();
    check("t5_release", 32'(last_rdy[0]), 32'h2);
    idle_all();

    // Reset between a read accept and its response.
    apply_reset();
    idle_all();
    drive(0, 0, 1'b1, 1'b1, 1'b1, 3, '0);
    cycle();
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_rspv", 32'(rspv[0]), 32'h0);
    check("t6_cen", 32'(cen[0]), 32'h1);
    check("t6_ready", 32'(rdy[0]), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle_all();
    drive(0, 1, 1'b1, 1'b1, 1'b0, 4, '0);
    cycle();
    check("t6_arb_after", 32'(last_rdy[0]), 32'h2);
    idle_all();
    cycle();

    // Randomised traffic with short and long lock bursts plus one mid-run reset.
    for (int k = 0; k < 800; k++) begin
      if (k == 400) apply_reset();
      rand_drive(k >= 400);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
